// File: rtl/conv_kernel_scheduler_if.sv
// Window/kernel-side bus of conv_kernel_scheduler: window handshake, buffer
// addressing, bias select and the tagged result stream.
interface conv_kernel_scheduler_if #(
  parameter int GRP_W = 6
) ();
  logic                 win_valid;
  logic                 win_ready;
  logic                 ifm_zero_sel;
  logic [2*GRP_W-1:0]   weight_addr;
  logic [GRP_W-1:0]     bias_addr;
  logic                 bias_valid;
  logic                 ofm_valid;
  logic [GRP_W-1:0]     ofm_oc_grp;
  logic                 ofm_last;

  modport master (
    input  win_valid,
    output win_ready, ifm_zero_sel, weight_addr, bias_addr, bias_valid,
           ofm_valid, ofm_oc_grp, ofm_last
  );

  modport slave (
    output win_valid,
    input  win_ready, ifm_zero_sel, weight_addr, bias_addr, bias_valid,
           ofm_valid, ofm_oc_grp, ofm_last
  );
endinterface

// File: rtl/conv_kernel_scheduler.sv
// Walks oc_grp/pix/ic_grp for one conv tile, addresses weight/bias buffers and
// tags kernel results. Optional stall statistics: define SCHED_STALL_STATS_EN.
module conv_kernel_scheduler #(
  parameter int PIX_W    = 16,
  parameter int GRP_W    = 6,
  parameter int PIPE_LAT = 6
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 cfg_start,
  input  logic [PIX_W-1:0]     cfg_num_pix,
  input  logic [GRP_W-1:0]     cfg_num_ic_grp,
  input  logic [GRP_W-1:0]     cfg_num_oc_grp,
  conv_kernel_scheduler_if.master bus,
  output logic                 busy,
  output logic                 done,
  output logic [31:0]          stat_stall_cnt
);
  localparam int AW = 2 * GRP_W;
  localparam logic [PIPE_LAT-1:0] HEAD_MASK = PIPE_LAT'(1) << (PIPE_LAT - 1);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN, S_DONE} state_t;
  state_t state, state_nxt;

  logic [PIX_W-1:0] num_pix, pix;
  logic [GRP_W-1:0] num_ic, num_oc, ic, oc;
  logic             start_ok, cfg_zero, fire;
  logic             ic_last, pix_last, oc_last, tile_last, tags_pending;

  logic [PIPE_LAT-1:0] tag_v, tag_l;
  logic [GRP_W-1:0]    tag_oc [PIPE_LAT];

  always_comb begin
    start_ok     = (state == S_IDLE) && cfg_start;
    cfg_zero     = (cfg_num_pix == '0) || (cfg_num_ic_grp == '0) || (cfg_num_oc_grp == '0);
    fire         = (state == S_RUN) && bus.win_valid;
    ic_last      = (ic == num_ic - GRP_W'(1));
    pix_last     = (pix == num_pix - PIX_W'(1));
    oc_last      = (oc == num_oc - GRP_W'(1));
    tile_last    = ic_last && pix_last && oc_last;
    // The head entry is leaving this cycle, so only younger stages keep DRAIN alive.
    tags_pending = |(tag_v & ~HEAD_MASK);

    state_nxt = state;
    case (state)
      S_IDLE:  if (cfg_start) state_nxt = cfg_zero ? S_DONE : S_RUN;
      S_RUN:   if (fire && tile_last) state_nxt = S_DRAIN;
      S_DRAIN: if (!tags_pending) state_nxt = S_DONE;
      S_DONE:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    bus.win_ready    = (state == S_RUN);
    bus.ifm_zero_sel = ~fire;
    bus.bias_valid   = fire && (ic == '0);
    bus.weight_addr  = AW'(oc) * AW'(num_ic) + AW'(ic);
    bus.bias_addr    = oc;
    bus.ofm_valid    = tag_v[PIPE_LAT-1];
    bus.ofm_last     = tag_l[PIPE_LAT-1];
    bus.ofm_oc_grp   = tag_oc[PIPE_LAT-1];
    busy             = (state != S_IDLE);
    done             = (state == S_DONE);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      num_pix <= '0;
      num_ic  <= '0;
      num_oc  <= '0;
      pix     <= '0;
      ic      <= '0;
      oc      <= '0;
    end else if (start_ok) begin
      num_pix <= cfg_num_pix;
      num_ic  <= cfg_num_ic_grp;
      num_oc  <= cfg_num_oc_grp;
      pix     <= '0;
      ic      <= '0;
      oc      <= '0;
    end else if (fire) begin
      if (!ic_last) begin
        ic <= ic + GRP_W'(1);
      end else begin
        ic <= '0;
        if (!pix_last) begin
          pix <= pix + PIX_W'(1);
        end else begin
          pix <= '0;
          oc  <= oc_last ? '0 : oc + GRP_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tag_v <= '0;
      tag_l <= '0;
      for (int unsigned i = 0; i < PIPE_LAT; i++) tag_oc[i] <= '0;
    end else begin
      for (int unsigned i = PIPE_LAT - 1; i > 0; i--) begin
        tag_v[i]  <= tag_v[i-1];
        tag_l[i]  <= tag_l[i-1];
        tag_oc[i] <= tag_oc[i-1];
      end
      tag_v[0]  <= fire && ic_last;
      tag_l[0]  <= fire && tile_last;
      tag_oc[0] <= oc;
    end
  end

`ifdef SCHED_STALL_STATS_EN
  logic [31:0] stall_cnt;
  always_ff @(posedge clk) begin
    if (rst || start_ok)
      stall_cnt <= '0;
    else if ((state == S_RUN) && !bus.win_valid && (stall_cnt != '1))
      stall_cnt <= stall_cnt + 32'd1;
  end
  assign stat_stall_cnt = stall_cnt;
`else
  assign stat_stall_cnt = '0;
`endif
endmodule

// File: tb/tb_conv_kernel_scheduler.sv
// Bench for conv_kernel_scheduler: transaction-level model checked every cycle
// plus literal cycle/address expectations for the directed tiles.
module tb_conv_kernel_scheduler;
  localparam int PIX_W = 16, GRP_W = 6, PIPE_LAT = 6;

  logic clk = 1'b0, rst = 1'b1, cfg_start = 1'b0;
  logic [PIX_W-1:0] cfg_num_pix = '0;
  logic [GRP_W-1:0] cfg_num_ic_grp = '0, cfg_num_oc_grp = '0;
  logic busy, done;
  logic [31:0] stat_stall_cnt;

  conv_kernel_scheduler_if #(.GRP_W(GRP_W)) bus ();

  conv_kernel_scheduler #(.PIX_W(PIX_W), .GRP_W(GRP_W), .PIPE_LAT(PIPE_LAT)) dut (
    .clk(clk), .rst(rst), .cfg_start(cfg_start), .cfg_num_pix(cfg_num_pix),
    .cfg_num_ic_grp(cfg_num_ic_grp), .cfg_num_oc_grp(cfg_num_oc_grp),
    .bus(bus), .busy(busy), .done(done), .stat_stall_cnt(stat_stall_cnt));

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec = 0, n_err = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic chk_q(input string name, input int act[$], input int exp[$]);
    chk({name, ".len"}, act.size(), exp.size());
    for (int i = 0; i < act.size() && i < exp.size(); i++)
      chk($sformatf("%s[%0d]", name, i), act[i], exp[i]);
  endtask

  // Logs of DUT activity relative to the start cycle of the current tile.
  int log_base = 0;
  int ofm_log[$], last_log[$], done_log[$], bias_log[$], wa_log[$], ba_log[$], oc_log[$];
  int ready_cnt = 0;
  bit done_seen = 0;

  // Model: the tile is a queue of (oc, ic) work items in loop order; results are
  // scheduled by absolute cycle number.
  int  q_oc[$], q_ic[$];
  bit  sch_v[int], sch_l[int];
  int  sch_oc[int];
  bit  m_active = 0;
  int  m_done_cyc = -1;
  int  m_nic = 0;
  longint m_stall = 0;

  always @(negedge clk) begin
    int c;
    bit exp_ready, fire, ev;
    c = cyc;
    if (rst) begin
      q_oc.delete(); q_ic.delete();
      sch_v.delete(); sch_l.delete(); sch_oc.delete();
      m_active = 0; m_done_cyc = -1; m_stall = 0;
    end else begin
      exp_ready = (q_oc.size() > 0);
      fire = bus.win_valid && exp_ready;
      chk("win_ready", bus.win_ready, exp_ready);
      chk("ifm_zero_sel", bus.ifm_zero_sel, !fire);
      chk("bias_valid", bus.bias_valid, fire && q_ic[0] == 0);
      if (fire) begin
        chk("weight_addr", bus.weight_addr, q_oc[0] * m_nic + q_ic[0]);
        chk("bias_addr", bus.bias_addr, q_oc[0]);
      end
      ev = sch_v.exists(c);
      chk("ofm_valid", bus.ofm_valid, ev);
      chk("ofm_last", bus.ofm_last, ev && sch_l[c]);
      if (ev) chk("ofm_oc_grp", bus.ofm_oc_grp, sch_oc[c]);
      chk("done", done, c == m_done_cyc);
      chk("busy", busy, m_active);
`ifdef SCHED_STALL_STATS_EN
      chk("stat_stall_cnt", stat_stall_cnt, m_stall);
`else
      chk("stat_stall_cnt", stat_stall_cnt, 0);
`endif
      if (bus.ofm_valid) begin ofm_log.push_back(c - log_base); oc_log.push_back(int'(bus.ofm_oc_grp)); end
      if (bus.ofm_last) last_log.push_back(c - log_base);
      if (done) begin done_log.push_back(c - log_base); done_seen = 1; end
      if (bus.bias_valid) bias_log.push_back(c - log_base);
      if (bus.win_ready) ready_cnt++;
      if (bus.win_valid && bus.win_ready) begin
        wa_log.push_back(int'(bus.weight_addr));
        ba_log.push_back(int'(bus.bias_addr));
      end

      if (exp_ready && !bus.win_valid) m_stall++;
      if (fire) begin
        int oc_i, ic_i;
        oc_i = q_oc.pop_front();
        ic_i = q_ic.pop_front();
        if (ic_i == m_nic - 1) begin
          sch_v[c + PIPE_LAT] = 1;
          sch_oc[c + PIPE_LAT] = oc_i;
          sch_l[c + PIPE_LAT] = (q_oc.size() == 0);
          if (q_oc.size() == 0) m_done_cyc = c + PIPE_LAT + 1;
        end
      end
      if (cfg_start && !m_active) begin
        m_active = 1;
        m_stall = 0;
        m_nic = int'(cfg_num_ic_grp);
        if (cfg_num_pix == 0 || cfg_num_ic_grp == 0 || cfg_num_oc_grp == 0)
          m_done_cyc = c + 1;
        else
          for (int o = 0; o < int'(cfg_num_oc_grp); o++)
            for (int p = 0; p < int'(cfg_num_pix); p++)
              for (int i = 0; i < int'(cfg_num_ic_grp); i++) begin
                q_oc.push_back(o);
                q_ic.push_back(i);
              end
      end else if (c == m_done_cyc) begin
        m_active = 0;
      end
    end
  end

  task automatic clear_logs();
    ofm_log.delete(); last_log.delete(); done_log.delete(); bias_log.delete();
    wa_log.delete(); ba_log.delete(); oc_log.delete();
    ready_cnt = 0; done_seen = 0;
  endtask

  // Start at relative cycle 0; win_valid low for rel cycles slo..shi; extra
  // cfg_start pulse at rel cycle dup (ignored while busy); cfg scrambled afterwards.
  task automatic run_tile(input int noc, input int npix, input int nic,
                          input int slo, input int shi, input int dup);
    @(posedge clk); #1;
    log_base = cyc;
    clear_logs();
    cfg_num_oc_grp = GRP_W'(noc);
    cfg_num_pix = PIX_W'(npix);
    cfg_num_ic_grp = GRP_W'(nic);
    cfg_start = 1'b1;
    bus.win_valid = 1'b1;
    for (int k = 1; k <= 300; k++) begin
      @(posedge clk); #1;
      cfg_start = (k == dup);
      cfg_num_oc_grp = 6'd7; cfg_num_pix = 16'd9; cfg_num_ic_grp = 6'd5;
      bus.win_valid = !(k >= slo && k <= shi);
      if (done_seen) break;
    end
    cfg_start = 1'b0;
    if (!done_seen) chk("tile_timeout", 0, 1);
    repeat (2) @(posedge clk);
  endtask

  initial begin
    bus.win_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("reset.busy", busy, 0);
    chk("reset.ofm_valid", bus.ofm_valid, 0);
    chk("reset.win_ready", bus.win_ready, 0);
    chk("reset.weight_addr", bus.weight_addr, 0);

    // Baseline tile, no stalls.
    run_tile(1, 4, 2, -1, -1, -1);
    chk_q("t1.ofm", ofm_log, '{8, 10, 12, 14});
    chk_q("t1.last", last_log, '{14});
    chk_q("t1.done", done_log, '{15});
    chk_q("t1.bias", bias_log, '{1, 3, 5, 7});

    // Same tile, three stall cycles.
    run_tile(1, 4, 2, 2, 4, -1);
    chk_q("t2.ofm", ofm_log, '{11, 13, 15, 17});
    chk_q("t2.done", done_log, '{18});
`ifdef SCHED_STALL_STATS_EN
    chk("t2.stall", stat_stall_cnt, 3);
`endif

    // Two oc groups, one pixel, three ic groups; spurious start mid-run.
    run_tile(2, 1, 3, -1, -1, 3);
    chk_q("t3.waddr", wa_log, '{0, 1, 2, 3, 4, 5});
    chk_q("t3.baddr", ba_log, '{0, 0, 0, 1, 1, 1});
    chk_q("t3.oc", oc_log, '{0, 1});

    // Zero pixel count: straight to done.
    run_tile(4, 0, 2, -1, -1, -1);
    chk_q("t4.done", done_log, '{1});
    chk("t4.ready", ready_cnt, 0);
    chk("t4.busy", busy, 0);

    // Single ic group: every fire loads bias and produces a result.
    run_tile(1, 3, 1, -1, -1, -1);
    chk_q("t5.bias", bias_log, '{1, 2, 3});
    chk_q("t5.ofm", ofm_log, '{7, 8, 9});
    chk_q("t5.done", done_log, '{10});

    // Reset after three fires, then a clean tile.
    @(posedge clk); #1;
    cfg_num_oc_grp = 6'd1; cfg_num_pix = 16'd4; cfg_num_ic_grp = 6'd2;
    cfg_start = 1'b1; bus.win_valid = 1'b1;
    repeat (3) begin @(posedge clk); #1 cfg_start = 1'b0; end
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    clear_logs();
    @(negedge clk);
    chk("rst.ofm_valid", bus.ofm_valid, 0);
    chk("rst.busy", busy, 0);
    chk("rst.bias_valid", bus.bias_valid, 0);
    repeat (15) @(posedge clk);
    chk("rst.ofm_after", ofm_log.size(), 0);
    chk("rst.done_after", done_log.size(), 0);
    run_tile(1, 4, 2, -1, -1, -1);
    chk_q("t6.ofm", ofm_log, '{8, 10, 12, 14});
    chk_q("t6.done", done_log, '{15});

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
